yin_sample_scheduler: RTL and testbench

- Sits between the audio front end (decimated ADC/I2S stream) and the yin pitch core.
- Buffers bursty incoming samples in a small FIFO.
- Paces them into yin no faster than yin can consume, with one sample per SAMPLE_GAP cycles.
- Tracks window boundaries and collects each window's taumin.
- Publishes a qualified pitch period, and flags overruns and lost results.

---
 rtl/yin_pkg.sv | 15 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/yin_sample_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_yin_sample_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/yin_pkg.sv
// Shared constants and types for the yin pitch-tracking front end.
package yin_pkg;

  localparam int unsigned WIDTH       = 16;
  localparam int unsigned WINDOW_SIZE = 2048;
  localparam int unsigned TAUMAX      = 2048;

  typedef logic [$clog2(TAUMAX)-1:0] tau_t;

  typedef enum logic {
    IDLE,
    GAP
  } sched_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags held in flops; push when full is ignored
// unless a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty_q;
  assign do_push = push && (!full_q || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/yin_sample_scheduler.sv
// Paces buffered audio samples into the yin core and qualifies its per-window taumin.
// Optional YIN_MEDIAN3_EN: publish the median of the last three captured taumin values.
module yin_sample_scheduler #(
  parameter int unsigned WIDTH          = yin_pkg::WIDTH,
  parameter int unsigned WINDOW_SIZE    = yin_pkg::WINDOW_SIZE,
  parameter int unsigned TAUMAX         = yin_pkg::TAUMAX,
  parameter int unsigned FIFO_DEPTH     = 64,
  parameter int unsigned SAMPLE_GAP     = 1040,
  parameter int unsigned RESULT_TIMEOUT = 65535,
  parameter int unsigned MIN_TAU        = 20
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic [WIDTH-1:0]               audio_in,
  input  logic                           audio_valid_in,
  output logic                           audio_ready_out,
  output logic [WIDTH-1:0]               yin_sample_out,
  output logic                           yin_valid_out,
  input  logic                           yin_result_valid_in,
  input  logic [$clog2(TAUMAX)-1:0]      yin_taumin_in,
  output logic [$clog2(TAUMAX)-1:0]      period_out,
  output logic                           voiced_out,
  output logic                           period_valid_out,
  output logic                           overrun_out,
  output logic                           timeout_out,
  output logic [$clog2(WINDOW_SIZE)-1:0] sample_idx_out
);

  import yin_pkg::*;

  localparam int unsigned TW = $clog2(TAUMAX);
  localparam int unsigned IW = $clog2(WINDOW_SIZE);
  localparam int unsigned GW = $clog2(SAMPLE_GAP);
  localparam int unsigned CW = $clog2(RESULT_TIMEOUT + 1);

  logic             fifo_full, fifo_empty, pop;
  logic [WIDTH-1:0] fifo_data;

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk_in),
    .rst_n(rst_n_in),
    .push (audio_valid_in),
    .pop  (pop),
    .wdata(audio_in),
    .rdata(fifo_data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // A pop in this cycle frees a slot, so a full FIFO can still take a sample.
  assign audio_ready_out = !fifo_full || pop;

  sched_state_t     state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [WIDTH-1:0] sample_q;
  logic             yin_valid_q;
  logic [IW-1:0]    idx_q;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          gap_d   = GW'(SAMPLE_GAP - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == GW'(1)) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      sample_q    <= '0;
      yin_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      yin_valid_q <= pop;
      if (pop) begin
        sample_q <= fifo_data;
        idx_q    <= (idx_q == IW'(WINDOW_SIZE - 1)) ? '0 : idx_q + 1'b1;
      end
    end
  end

  logic          pending_q, overrun_q, timeout_q;
  logic [CW-1:0] tmo_q;
  logic          wrap, capture, expire;

  assign wrap    = pop && (idx_q == IW'(WINDOW_SIZE - 1));
  assign capture = yin_result_valid_in && pending_q;
  // Expiry fires on the last counted cycle; a result in that cycle takes priority.
  assign expire  = pending_q && !capture && (tmo_q == CW'(1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pending_q <= 1'b0;
      tmo_q     <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (wrap) begin
        pending_q <= 1'b1;
        tmo_q     <= CW'(RESULT_TIMEOUT);
      end else if (capture || expire) begin
        pending_q <= 1'b0;
      end else if (pending_q) begin
        tmo_q <= tmo_q - 1'b1;
      end
      if (expire) timeout_q <= 1'b1;
      if (audio_valid_in && !audio_ready_out) overrun_q <= 1'b1;
    end
  end

  logic [TW-1:0] period_q;
  logic          voiced_q, pv_q;

`ifdef YIN_MEDIAN3_EN
  logic [TW-1:0] hist0_q, hist1_q, hist2_q;
  logic [TW-1:0] lo01, hi01, hi_c, med;
  logic          med_go_q;

  // median(a,b,c) = max(min(a,b), min(max(a,b), c))
  always_comb begin
    lo01 = (hist0_q < hist1_q) ? hist0_q : hist1_q;
    hi01 = (hist0_q < hist1_q) ? hist1_q : hist0_q;
    hi_c = (hi01 < hist2_q) ? hi01 : hist2_q;
    med  = (lo01 > hi_c) ? lo01 : hi_c;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hist0_q  <= '0;
      hist1_q  <= '0;
      hist2_q  <= '0;
      med_go_q <= 1'b0;
      period_q <= '0;
      voiced_q <= 1'b0;
      pv_q     <= 1'b0;
    end else begin
      med_go_q <= capture;
      pv_q     <= med_go_q;
      if (capture) begin
        hist0_q <= yin_taumin_in;
        hist1_q <= hist0_q;
        hist2_q <= hist1_q;
      end
      if (med_go_q) begin
        period_q <= med;
        voiced_q <= (med >= TW'(MIN_TAU));
      end
    end
  end
`else
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      period_q <= '0;
      voiced_q <= 1'b0;
      pv_q     <= 1'b0;
    end else begin
      pv_q <= capture;
      if (capture) begin
        period_q <= yin_taumin_in;
        voiced_q <= (yin_taumin_in >= TW'(MIN_TAU));
      end
    end
  end
`endif

  assign yin_sample_out   = sample_q;
  assign yin_valid_out    = yin_valid_q;
  assign sample_idx_out   = idx_q;
  assign period_out       = period_q;
  assign voiced_out       = voiced_q;
  assign period_valid_out = pv_q;
  assign overrun_out      = overrun_q;
  assign timeout_out      = timeout_q;

endmodule

// File: tb/tb_yin_sample_scheduler.sv
// Directed and randomized bench for yin_sample_scheduler against a queue/deadline model.
module tb_yin_sample_scheduler;

  localparam int WIDTH   = 16;
  localparam int WIN     = 8;
  localparam int TAUMAX  = 2048;
  localparam int DEPTH   = 4;
  localparam int GAP     = 4;
  localparam int TMO     = 20;
  localparam int MIN_TAU = 5;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic [15:0] audio_in = '0;
  logic        audio_valid_in = 1'b0;
  logic        audio_ready_out;
  logic [15:0] yin_sample_out;
  logic        yin_valid_out;
  logic        yin_result_valid_in = 1'b0;
  logic [10:0] yin_taumin_in = '0;
  logic [10:0] period_out;
  logic        voiced_out, period_valid_out, overrun_out, timeout_out;
  logic [2:0]  sample_idx_out;

  yin_sample_scheduler #(
    .WIDTH         (WIDTH),
    .WINDOW_SIZE   (WIN),
    .TAUMAX        (TAUMAX),
    .FIFO_DEPTH    (DEPTH),
    .SAMPLE_GAP    (GAP),
    .RESULT_TIMEOUT(TMO),
    .MIN_TAU       (MIN_TAU)
  ) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .audio_in           (audio_in),
    .audio_valid_in     (audio_valid_in),
    .audio_ready_out    (audio_ready_out),
    .yin_sample_out     (yin_sample_out),
    .yin_valid_out      (yin_valid_out),
    .yin_result_valid_in(yin_result_valid_in),
    .yin_taumin_in      (yin_taumin_in),
    .period_out         (period_out),
    .voiced_out         (voiced_out),
    .period_valid_out   (period_valid_out),
    .overrun_out        (overrun_out),
    .timeout_out        (timeout_out),
    .sample_idx_out     (sample_idx_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue for the buffer, the edge of the last feed, and a result deadline.
  logic [15:0] q[$];
  int cyc = 0;
  int last_pop, m_idx, m_deadline, m_period;
  bit m_pend, m_voiced, m_pv, m_ovr, m_tmo, m_yv;
  logic [15:0] m_sample;

  task automatic model_reset();
    q.delete();
    last_pop   = cyc - 100;
    m_idx      = 0;
    m_deadline = 0;
    m_period   = 0;
    m_pend     = 0;
    m_voiced   = 0;
    m_pv       = 0;
    m_ovr      = 0;
    m_tmo      = 0;
    m_yv       = 0;
    m_sample   = '0;
  endtask

  task automatic cycle(input bit v, input int d, input bit rv, input int tau);
    bit pop, acc, wrap;
    audio_valid_in      = v;
    audio_in            = d[15:0];
    yin_result_valid_in = rv;
    yin_taumin_in       = tau[10:0];
    pop = (q.size() > 0) && (cyc + 1 - last_pop >= GAP);
    chk("ready", {31'd0, audio_ready_out}, {31'd0, (q.size() < DEPTH) || pop});
    @(posedge clk_in);
    cyc++;
    acc  = v && ((q.size() < DEPTH) || pop);
    m_yv = 0;
    m_pv = 0;
    wrap = 0;
    if (pop) begin
      m_sample = q.pop_front();
      m_yv     = 1;
      last_pop = cyc;
      m_idx    = (m_idx + 1) % WIN;
      wrap     = (m_idx == 0);
    end
    if (acc) q.push_back(d[15:0]);
    else if (v) m_ovr = 1;
    if (rv && m_pend) begin
      m_period = tau;
      m_voiced = (tau >= MIN_TAU);
      m_pv     = 1;
      m_pend   = 0;
    end else if (m_pend && cyc == m_deadline) begin
      m_tmo  = 1;
      m_pend = 0;
    end
    if (wrap) begin
      m_pend     = 1;
      m_deadline = cyc + TMO;
    end
    #1;
    chk("yin_valid", {31'd0, yin_valid_out}, {31'd0, m_yv});
    chk("yin_sample", {16'd0, yin_sample_out}, {16'd0, m_sample});
    chk("sample_idx", {29'd0, sample_idx_out}, m_idx);
    chk("period_valid", {31'd0, period_valid_out}, {31'd0, m_pv});
    chk("period", {21'd0, period_out}, m_period);
    chk("voiced", {31'd0, voiced_out}, {31'd0, m_voiced});
    chk("overrun", {31'd0, overrun_out}, {31'd0, m_ovr});
    chk("timeout", {31'd0, timeout_out}, {31'd0, m_tmo});
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0);
  endtask

  task automatic feed_window(input int base);
    for (int i = 0; i < WIN; i++) begin
      cycle(1, base + i, 0, 0);
      idle(3);
    end
  endtask

  // Asserts reset mid-cycle and checks the asynchronous reset values before any clock edge.
  task automatic do_reset();
    @(posedge clk_in);
    #2;
    rst_n_in            = 1'b0;
    audio_valid_in      = 1'b0;
    yin_result_valid_in = 1'b0;
    #1;
    chk("rst_ready", {31'd0, audio_ready_out}, 32'd1);
    chk("rst_yin_valid", {31'd0, yin_valid_out}, 32'd0);
    chk("rst_yin_sample", {16'd0, yin_sample_out}, 32'd0);
    chk("rst_period", {21'd0, period_out}, 32'd0);
    chk("rst_voiced", {31'd0, voiced_out}, 32'd0);
    chk("rst_pv", {31'd0, period_valid_out}, 32'd0);
    chk("rst_overrun", {31'd0, overrun_out}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_out}, 32'd0);
    chk("rst_idx", {29'd0, sample_idx_out}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    do_reset();

    // Burst of four, then drain: strobes every GAP cycles in order.
    for (int i = 0; i < 4; i++) cycle(1, 16'h0011 + i, 0, 0);
    idle(16);
    chk("idx_after_burst", {29'd0, sample_idx_out}, 32'd4);
    chk("no_overrun_burst", {31'd0, overrun_out}, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1, 16'h0015 + i, 0, 0);
    idle(16);
    chk("idx_wrapped", {29'd0, sample_idx_out}, 32'd0);

    // Voiced result for the first window.
    cycle(0, 0, 1, 37);
    chk("pv_37", {31'd0, period_valid_out}, 32'd1);
    chk("period_37", {21'd0, period_out}, 32'd37);
    chk("voiced_37", {31'd0, voiced_out}, 32'd1);
    idle(1);
    chk("pv_one_cycle", {31'd0, period_valid_out}, 32'd0);

    // Unvoiced result for the next window.
    feed_window(16'h0020);
    cycle(0, 0, 1, 3);
    chk("period_3", {21'd0, period_out}, 32'd3);
    chk("voiced_3", {31'd0, voiced_out}, 32'd0);

    // Result lands in the very cycle the timeout would expire.
    feed_window(16'h0030);
    while (cyc + 1 < m_deadline) idle(1);
    cycle(0, 0, 1, 9);
    chk("late_edge_period", {21'd0, period_out}, 32'd9);
    chk("late_edge_no_timeout", {31'd0, timeout_out}, 32'd0);

    // No result: timeout, then a late result is ignored.
    feed_window(16'h0040);
    idle(25);
    chk("timeout_set", {31'd0, timeout_out}, 32'd1);
    chk("timeout_period_held", {21'd0, period_out}, 32'd9);
    cycle(0, 0, 1, 50);
    chk("late_ignored_pv", {31'd0, period_valid_out}, 32'd0);
    chk("late_ignored_period", {21'd0, period_out}, 32'd9);

    // Continuous input overflows the buffer.
    for (int i = 0; i < 12; i++) cycle(1, 16'h0100 + i, 0, 0);
    chk("overrun_set", {31'd0, overrun_out}, 32'd1);
    idle(40);

    // Randomized traffic and results.
    repeat (400) begin
      cycle($urandom_range(0, 9) < 4, int'($urandom_range(0, 65535)),
            $urandom_range(0, 19) == 0, int'($urandom_range(0, 12)));
    end

    // Reset in the middle of a gap, then first sample strobes two cycles after it arrives.
    idle(30);
    cycle(1, 16'h00ab, 0, 0);
    idle(1);
    chk("pre_reset_strobe", {31'd0, yin_valid_out}, 32'd1);
    do_reset();
    cycle(1, 16'h00cd, 0, 0);
    chk("post_reset_no_early", {31'd0, yin_valid_out}, 32'd0);
    idle(1);
    chk("post_reset_strobe", {31'd0, yin_valid_out}, 32'd1);
    chk("post_reset_sample", {16'd0, yin_sample_out}, 32'h00cd);
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
